// File: rtl/adder_ctrl_pkg.sv
// Shared encodings and width helper for the adder round-robin controller.
package adder_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_BUSY = S_BUSY,
    ST_RESP = S_RESP
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Client request/response bus plus the adder handshake seen by the arbiter.
interface adder_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 3
);
  import adder_ctrl_pkg::*;

  localparam int IW = clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       gnt;
  logic                   rsp_valid;
  logic [IW-1:0]          rsp_id;
  logic [WIDTH:0]         rsp_sum;
  logic                   rsp_err;
  logic                   add_en;
  logic [WIDTH-1:0]       add_a;
  logic [WIDTH-1:0]       add_b;
  logic [WIDTH:0]         add_out;
  logic                   add_done;

  // master is the arbiter; slave is the client/adder side
  modport master (
    input  req, req_a, req_b, add_out, add_done,
    output gnt, rsp_valid, rsp_id, rsp_sum, rsp_err, add_en, add_a, add_b
  );

  modport slave (
    output req, req_a, req_b, add_out, add_done,
    input  gnt, rsp_valid, rsp_id, rsp_sum, rsp_err, add_en, add_a, add_b
  );

endinterface

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_pick
  import adder_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  logic [IW-1:0] w_pos;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_pos    = '0;
    // Scan furthest to nearest so the last hit is the closest one at/after the pointer.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = IW'((int'(i_ptr) + k) % N_REQ);
      if (i_req[w_pos]) begin
        o_onehot        = '0;
        o_onehot[w_pos] = 1'b1;
        o_idx           = w_pos;
        o_any           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one multi-cycle adder among N_REQ requesters in round-robin order,
// returning each sum tagged with its requester id, or an error on adder timeout.
module adder_arbiter
  import adder_ctrl_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 3,
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  adder_arbiter_if.master bus
);

  localparam int IW = clog2(N_REQ);
  localparam int CW = clog2(MAX_WAIT + 1);

  state_t           r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic [WIDTH:0]   r_sum;
  logic             r_add_en;

  logic [N_REQ-1:0] w_onehot;
  logic [IW-1:0]    w_idx;
  logic             w_any;
  logic [WIDTH-1:0] w_a [N_REQ];
  logic [WIDTH-1:0] w_b [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_a[gi] = bus.req_a[gi*WIDTH +: WIDTH];
    assign w_b[gi] = bus.req_b[gi*WIDTH +: WIDTH];
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_sum       <= '0;
      r_add_en    <= 1'b0;
    end else begin
      r_gnt       <= '0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_id     <= w_idx;
            r_a      <= w_a[w_idx];
            r_b      <= w_b[w_idx];
            r_gnt    <= w_onehot;
            r_add_en <= 1'b1;
            r_cnt    <= '0;
            r_ptr    <= (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
            r_state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A done that coincides with the last allowed cycle still wins over the timeout.
          if (bus.add_done) begin
            r_sum       <= bus.add_out;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_add_en    <= 1'b0;
            r_state     <= ST_RESP;
          end else if (r_cnt == CW'(MAX_WAIT)) begin
            r_sum       <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_add_en    <= 1'b0;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_sum     <= '0;
          r_rsp_err <= 1'b0;
          r_id      <= '0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_sum   = r_sum;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.add_en    = r_add_en;
  assign bus.add_a     = r_a;
  assign bus.add_b     = r_b;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter with a behavioural multi-cycle adder and a round-robin reference model.
module tb_adder_arbiter;

  localparam int N  = 4;
  localparam int W  = 3;
  localparam int MW = 15;

  typedef struct {
    int           gnt_lat;
    int           rsp_lat;
    int           id;
    int           sum;
    int           op_a;
    int           op_b;
    logic [N-1:0] gnt;
    bit           err;
    bit           en_at_gnt;
    bit           en_at_rsp;
    bit           held;
    bit           stray_gnt;
    bit           rsp_long;
    bit           tmo;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_vec   = 0;
  int n_err   = 0;
  int exp_ptr = 0;
  int op_a_tbl [N];
  int op_b_tbl [N];

  // Adder model: mode 0 = done after add_lat extra cycles, 1 = never done, 2 = done always high
  int             add_mode = 0;
  int             add_lat  = 0;
  int             m_cnt    = 0;
  logic           m_done   = 1'b0;
  logic [W:0]     m_out    = '0;

  adder_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  adder_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_WAIT(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!bus.add_en || add_mode != 0) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else if (m_cnt >= add_lat) begin
      m_done <= 1'b1;
      m_out  <= {1'b0, bus.add_a} + {1'b0, bus.add_b};
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  assign bus.add_done = (add_mode == 2) ? 1'b1 : m_done;
  assign bus.add_out  = (add_mode == 2) ? ({1'b0, bus.add_a} + {1'b0, bus.add_b}) : m_out;

  function automatic int pick(input logic [N-1:0] rv, input int p);
    for (int k = 0; k < N; k++) begin
      if (rv[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    bus.req_a[i*W +: W] = W'(a);
    bus.req_b[i*W +: W] = W'(b);
    op_a_tbl[i] = a;
    op_b_tbl[i] = b;
  endtask

  // Drives one request vector and records what the DUT does; no judgement here.
  task automatic run_txn(input logic [N-1:0] rv, input bit hold, output obs_t o);
    o = '{default: 0};
    bus.req = rv;
    o.tmo = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (|bus.gnt) begin
        o.tmo = 1'b0;
        o.gnt_lat = n;
        break;
      end
    end
    if (o.tmo) begin
      bus.req = '0;
      return;
    end
    o.gnt       = bus.gnt;
    o.en_at_gnt = bus.add_en;
    o.op_a      = int'(bus.add_a);
    o.op_b      = int'(bus.add_b);
    o.held      = 1'b1;
    if (!hold) bus.req = rv & ~bus.gnt;
    o.tmo = 1'b1;
    for (int n = 1; n <= MW + 8; n++) begin
      tick();
      if (bus.gnt != '0) o.stray_gnt = 1'b1;
      if (bus.add_a !== W'(o.op_a) || bus.add_b !== W'(o.op_b)) o.held = 1'b0;
      if (bus.rsp_valid) begin
        o.tmo       = 1'b0;
        o.rsp_lat   = n;
        o.id        = int'(bus.rsp_id);
        o.sum       = int'(bus.rsp_sum);
        o.err       = bus.rsp_err;
        o.en_at_rsp = bus.add_en;
        break;
      end
    end
    tick();
    o.rsp_long = bus.rsp_valid;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.req_a = '0; bus.req_b = '0;
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.gnt, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_err} !== '0) begin
      n_err++;
      $display("FAIL reset_rsp: got %h want 0", {bus.gnt, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_err});
    end
    n_vec++;
    if ({bus.add_en, bus.add_a, bus.add_b} !== '0) begin
      n_err++;
      $display("FAIL reset_add: got %h want 0", {bus.add_en, bus.add_a, bus.add_b});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_vec++;
    if ({bus.gnt, bus.add_en, bus.rsp_valid} !== '0) begin
      n_err++;
      $display("FAIL reset_idle: got %h want 0", {bus.gnt, bus.add_en, bus.rsp_valid});
    end
    exp_ptr = 0;
    $display("reset: %0d vectors so far", n_vec);
  endtask

  task automatic test_single();
    obs_t o;
    int eid;
    logic [N-1:0] eg;
    add_mode = 0; add_lat = 1;
    set_ops(0, 3, 2);
    eid = pick(4'b0001, exp_ptr);
    eg = '0; eg[eid] = 1'b1;
    run_txn(4'b0001, 1'b0, o);
    bus.req = '0;
    n_vec++; if (o.tmo) begin n_err++; $display("FAIL single_tmo: got timeout want response"); end
    n_vec++; if (o.gnt !== eg) begin n_err++; $display("FAIL single_gnt: got %b want %b", o.gnt, eg); end
    n_vec++; if (o.gnt_lat != 1) begin n_err++; $display("FAIL single_gnt_lat: got %0d want 1", o.gnt_lat); end
    n_vec++; if (o.en_at_gnt !== 1'b1) begin n_err++; $display("FAIL single_en: got %0d want 1", o.en_at_gnt); end
    n_vec++; if (o.id != eid) begin n_err++; $display("FAIL single_id: got %0d want %0d", o.id, eid); end
    n_vec++; if (o.sum != op_a_tbl[eid] + op_b_tbl[eid]) begin n_err++; $display("FAIL single_sum: got %0d want %0d", o.sum, op_a_tbl[eid] + op_b_tbl[eid]); end
    n_vec++; if (o.err !== 1'b0) begin n_err++; $display("FAIL single_err: got %0d want 0", o.err); end
    n_vec++; if (o.rsp_lat != add_lat + 2) begin n_err++; $display("FAIL single_rsp_lat: got %0d want %0d", o.rsp_lat, add_lat + 2); end
    exp_ptr = (eid + 1) % N;
    $display("single: id=%0d sum=%0d err=%0d", o.id, o.sum, o.err);
  endtask

  task automatic test_reset_busy();
    logic [N-1:0] eg;
    bit seen;
    add_mode = 0; add_lat = 5;
    set_ops(1, 5, 6);
    eg = '0; eg[pick(4'b0010, exp_ptr)] = 1'b1;
    bus.req = 4'b0010;
    tick();
    n_vec++; if (bus.gnt !== eg) begin n_err++; $display("FAIL rbusy_gnt: got %b want %b", bus.gnt, eg); end
    bus.req = '0;
    tick(); tick();
    n_vec++; if (bus.add_en !== 1'b1) begin n_err++; $display("FAIL rbusy_en: got %0d want 1", bus.add_en); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.gnt, bus.rsp_valid, bus.rsp_err, bus.rsp_sum, bus.add_en, bus.add_a, bus.add_b} !== '0) begin
      n_err++;
      $display("FAIL rbusy_async: got %h want 0", {bus.gnt, bus.rsp_valid, bus.rsp_err, bus.rsp_sum, bus.add_en, bus.add_a, bus.add_b});
    end
    tick();
    rst_n = 1'b1;
    exp_ptr = 0;
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (bus.rsp_valid || bus.add_en) seen = 1'b1;
    end
    n_vec++; if (seen) begin n_err++; $display("FAIL rbusy_discard: got activity after reset want none"); end
    $display("reset_busy: in-flight op discarded=%0d", !seen);
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int eid;
    logic [N-1:0] eg;
    add_mode = 0; add_lat = 2;
    for (int i = 0; i < N; i++) set_ops(i, i, 7 - i);
    for (int t = 0; t < 5; t++) begin
      eid = pick(4'b1111, exp_ptr);
      eg = '0; eg[eid] = 1'b1;
      run_txn(4'b1111, 1'b1, o);
      n_vec++; if (o.gnt !== eg) begin n_err++; $display("FAIL b2b_gnt[%0d]: got %b want %b", t, o.gnt, eg); end
      n_vec++; if (o.id != eid) begin n_err++; $display("FAIL b2b_id[%0d]: got %0d want %0d", t, o.id, eid); end
      n_vec++; if (o.sum != op_a_tbl[eid] + op_b_tbl[eid]) begin n_err++; $display("FAIL b2b_sum[%0d]: got %0d want %0d", t, o.sum, op_a_tbl[eid] + op_b_tbl[eid]); end
      n_vec++; if (o.en_at_rsp !== 1'b0) begin n_err++; $display("FAIL b2b_en_gap[%0d]: got %0d want 0", t, o.en_at_rsp); end
      n_vec++; if (o.gnt_lat != 1) begin n_err++; $display("FAIL b2b_gnt_gap[%0d]: got %0d want 1", t, o.gnt_lat); end
      exp_ptr = (eid + 1) % N;
      $display("b2b[%0d]: gnt=%b id=%0d sum=%0d", t, o.gnt, o.id, o.sum);
    end
    bus.req = '0;
  endtask

  task automatic test_overflow();
    obs_t o;
    int eid;
    add_mode = 0; add_lat = 0;
    set_ops(0, 7, 4);
    eid = pick(4'b0001, exp_ptr);
    run_txn(4'b0001, 1'b0, o);
    bus.req = '0;
    n_vec++; if (o.id != eid) begin n_err++; $display("FAIL ovf_id: got %0d want %0d", o.id, eid); end
    n_vec++; if (o.sum != 11) begin n_err++; $display("FAIL ovf_sum: got %0d want 11", o.sum); end
    exp_ptr = (eid + 1) % N;
    $display("overflow: 7+4 -> %0d", o.sum);
  endtask

  task automatic test_timeout();
    obs_t o;
    int eid;
    add_mode = 1;
    set_ops(1, 2, 3);
    eid = pick(4'b0010, exp_ptr);
    run_txn(4'b0010, 1'b0, o);
    bus.req = '0;
    n_vec++; if (o.tmo) begin n_err++; $display("FAIL tmo_rsp: got no response want error response"); end
    n_vec++; if (o.err !== 1'b1) begin n_err++; $display("FAIL tmo_err: got %0d want 1", o.err); end
    n_vec++; if (o.sum != 0) begin n_err++; $display("FAIL tmo_sum: got %0d want 0", o.sum); end
    n_vec++; if (o.rsp_lat != MW + 1) begin n_err++; $display("FAIL tmo_lat: got %0d want %0d", o.rsp_lat, MW + 1); end
    n_vec++; if (o.id != eid) begin n_err++; $display("FAIL tmo_id: got %0d want %0d", o.id, eid); end
    exp_ptr = (eid + 1) % N;
    add_mode = 0;
    $display("timeout: err=%0d after %0d cycles", o.err, o.rsp_lat);
  endtask

  task automatic test_done_early();
    obs_t o;
    int eid;
    bit seen;
    add_mode = 2;
    seen = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (bus.rsp_valid) seen = 1'b1;
    end
    n_vec++; if (seen) begin n_err++; $display("FAIL early_idle: got rsp_valid in idle want none"); end
    set_ops(3, 6, 5);
    eid = pick(4'b1000, exp_ptr);
    run_txn(4'b1000, 1'b0, o);
    bus.req = '0;
    n_vec++; if (o.rsp_lat != 1) begin n_err++; $display("FAIL early_lat: got %0d want 1", o.rsp_lat); end
    n_vec++; if (o.sum != 11 || o.err !== 1'b0) begin n_err++; $display("FAIL early_sum: got %0d/%0d want 11/0", o.sum, o.err); end
    exp_ptr = (eid + 1) % N;
    add_mode = 0;
    $display("done_early: lat=%0d sum=%0d", o.rsp_lat, o.sum);
  endtask

  task automatic test_wrap();
    obs_t o;
    int eid;
    logic [N-1:0] rv_list [3];
    rv_list[0] = 4'b0100; rv_list[1] = 4'b0100; rv_list[2] = 4'b1100;
    add_mode = 0; add_lat = 0;
    set_ops(2, 1, 1); set_ops(3, 4, 2);
    for (int t = 0; t < 3; t++) begin
      eid = pick(rv_list[t], exp_ptr);
      run_txn(rv_list[t], 1'b0, o);
      bus.req = '0;
      n_vec++; if (o.id != eid) begin n_err++; $display("FAIL wrap_id[%0d]: got %0d want %0d (ptr %0d)", t, o.id, eid, exp_ptr); end
      exp_ptr = (eid + 1) % N;
      $display("wrap[%0d]: req=%b id=%0d", t, rv_list[t], o.id);
    end
  endtask

  task automatic test_random();
    obs_t o;
    int eid;
    logic [N-1:0] rv;
    logic [N-1:0] eg;
    for (int t = 0; t < 24; t++) begin
      add_mode = 0;
      add_lat = int'($urandom_range(0, 5));
      for (int i = 0; i < N; i++) set_ops(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      rv = N'($urandom_range(1, 15));
      eid = pick(rv, exp_ptr);
      eg = '0; eg[eid] = 1'b1;
      run_txn(rv, 1'b0, o);
      bus.req = '0;
      n_vec++; if (o.gnt !== eg) begin n_err++; $display("FAIL rnd_gnt[%0d]: got %b want %b", t, o.gnt, eg); end
      n_vec++; if (o.id != eid) begin n_err++; $display("FAIL rnd_id[%0d]: got %0d want %0d", t, o.id, eid); end
      n_vec++; if (o.op_a != op_a_tbl[eid] || o.op_b != op_b_tbl[eid]) begin n_err++; $display("FAIL rnd_ops[%0d]: got %0d,%0d want %0d,%0d", t, o.op_a, o.op_b, op_a_tbl[eid], op_b_tbl[eid]); end
      n_vec++; if (o.sum != op_a_tbl[eid] + op_b_tbl[eid] || o.err !== 1'b0) begin n_err++; $display("FAIL rnd_sum[%0d]: got %0d/%0d want %0d/0", t, o.sum, o.err, op_a_tbl[eid] + op_b_tbl[eid]); end
      n_vec++; if (o.rsp_lat != add_lat + 2) begin n_err++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", t, o.rsp_lat, add_lat + 2); end
      n_vec++; if (!o.held || o.stray_gnt || o.rsp_long) begin n_err++; $display("FAIL rnd_proto[%0d]: got held=%0d stray_gnt=%0d rsp_long=%0d want 1/0/0", t, o.held, o.stray_gnt, o.rsp_long); end
      exp_ptr = (eid + 1) % N;
      $display("rnd[%0d]: req=%b lat=%0d id=%0d sum=%0d", t, rv, add_lat, o.id, o.sum);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_reset_busy();
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_done_early();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
